// File: rtl/apb_master_bridge_if.sv
// Local command/response stream plus APB4 requester bus for apb_master_bridge.
// The master modport is the bridge side; slave is the interconnect/APB-slave side.
interface apb_master_bridge_if #(
  parameter int AddrBits = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [AddrBits-1:0] cmd_addr;
  logic                cmd_write;
  logic [31:0]         cmd_wdata;
  logic [3:0]          cmd_strb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;

  logic [AddrBits-1:0] p_addr;
  logic                p_sel;
  logic                p_enable;
  logic                p_write;
  logic [31:0]         p_wdata;
  logic [3:0]          p_strb;
  logic [31:0]         p_rdata;
  logic                p_ready;
  logic                p_slverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    input  rsp_ready,
    input  p_rdata, p_ready, p_slverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output p_addr, p_sel, p_enable, p_write, p_wdata, p_strb
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    output rsp_ready,
    output p_rdata, p_ready, p_slverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  p_addr, p_sel, p_enable, p_write, p_wdata, p_strb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS on APB,
// response with read data / error out. ACCESS is bounded by a timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | p_sel high for one cycle, timeout counter cleared
// ACCESS | p_sel and p_enable high, waiting for p_ready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge #(
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 32
) (
  input logic               p_clk,
  input logic               p_resetn,
  apb_master_bridge_if.master bus
);

  localparam int CntBits = $clog2(TimeoutCycles + 1);
  localparam logic [CntBits-1:0] CntLast = CntBits'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state;
  logic [CntBits-1:0]  cnt;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [AddrBits-1:0] addr_q;
  logic                sel_q;
  logic                enable_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          strb_q;

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release, then stays high in IDLE
          if (cmd_ready_q && bus.cmd_valid) begin
            addr_q      <= bus.cmd_addr;
            write_q     <= bus.cmd_write;
            wdata_q     <= bus.cmd_wdata;
            strb_q      <= bus.cmd_write ? bus.cmd_strb : 4'b0000;
            sel_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state       <= SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          enable_q <= 1'b1;
          cnt      <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (bus.p_ready) begin
            rsp_err_q   <= bus.p_slverr;
            rsp_rdata_q <= (!write_q && !bus.p_slverr) ? bus.p_rdata : 32'h0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (cnt == CntLast) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'h0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.p_addr    = addr_q;
  assign bus.p_sel     = sel_q;
  assign bus.p_enable  = enable_q;
  assign bus.p_write   = write_q;
  assign bus.p_wdata   = wdata_q;
  assign bus.p_strb    = strb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: 64-word register-file slave with programmable wait
// states, directed corner cases plus randomized commands against a reference model.
module tb_apb_master_bridge;

  localparam int TC = 32;

  logic p_clk = 1'b0;
  logic p_resetn = 1'b0;
  always #5 p_clk = ~p_clk;

  apb_master_bridge_if #(.AddrBits(32)) bus_if ();

  apb_master_bridge #(.AddrBits(32), .TimeoutCycles(TC)) dut (
    .p_clk    (p_clk),
    .p_resetn (p_resetn),
    .bus      (bus_if)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Slave: words 62/63 are read-only (writes get an immediate slverr),
  // otherwise p_ready arrives after wait_cfg wait states.
  logic [31:0] mem [64];
  int          wait_cfg = 0;
  int          acc_cnt = 0;
  wire         sl_act = bus_if.p_sel & bus_if.p_enable;
  wire [5:0]   sl_idx = bus_if.p_addr[5:0];
  wire         sl_err = bus_if.p_write & (sl_idx >= 6'd62);

  assign bus_if.p_ready  = sl_act & (sl_err | (acc_cnt == wait_cfg));
  assign bus_if.p_slverr = sl_act & sl_err;
  assign bus_if.p_rdata  = bus_if.p_write ? 32'hDEAD_BEEF : mem[sl_idx];

  always @(posedge p_clk) begin
    if (sl_act && !bus_if.p_ready) acc_cnt <= acc_cnt + 1;
    else                           acc_cnt <= 0;
    if (sl_act && bus_if.p_ready && bus_if.p_write && !sl_err)
      for (int b = 0; b < 4; b++)
        if (bus_if.p_strb[b]) mem[sl_idx][b*8 +: 8] <= bus_if.p_wdata[b*8 +: 8];
  end

  // Reference model: expected outcome of one command from the protocol rules alone.
  logic [31:0] shadow [64];

  task automatic model_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int wt,
                           output logic [31:0] e_rdata, output logic e_err, output int e_acc);
    int idx;
    idx = int'(addr[5:0]);
    if (wr && idx >= 62) begin
      e_err = 1'b1; e_rdata = 32'h0; e_acc = 1;
    end else if (wt + 1 > TC) begin
      e_err = 1'b1; e_rdata = 32'h0; e_acc = TC;
    end else begin
      e_err = 1'b0; e_acc = wt + 1;
      if (wr) begin
        e_rdata = 32'h0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) shadow[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        e_rdata = shadow[idx];
      end
    end
  endtask

  // Must be called at a negedge; returns at a negedge with the bridge back in IDLE.
  task automatic do_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int wt, input int rsp_delay,
                        input bit hold, input bit chk_imm);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_acc;
    int          n;
    int          acc;
    logic [3:0]  e_strb;
    model_cmd(addr, wr, wdata, strb, wt, e_rdata, e_err, e_acc);
    e_strb = wr ? strb : 4'h0;
    wait_cfg = wt;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_write = wr;
    bus_if.cmd_wdata = wdata;
    bus_if.cmd_strb  = strb;
    bus_if.cmd_valid = 1'b1;
    n = 0;
    while (!bus_if.cmd_ready && n < 50) begin
      @(negedge p_clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'(n), 32'd0);
      bus_if.cmd_valid = 1'b0;
      return;
    end
    if (chk_imm) chk("b2b_accept_wait", 32'(n), 32'd0);
    @(negedge p_clk);
    chk("setup_sel", 32'(bus_if.p_sel), 32'd1);
    chk("setup_enable", 32'(bus_if.p_enable), 32'd0);
    chk("setup_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    chk("setup_addr", bus_if.p_addr, addr);
    if (!hold) bus_if.cmd_valid = 1'b0;
    @(negedge p_clk);
    acc = 0;
    while (bus_if.p_enable && acc < 200) begin
      acc++;
      chk("acc_sel", 32'(bus_if.p_sel), 32'd1);
      chk("acc_addr", bus_if.p_addr, addr);
      chk("acc_write", 32'(bus_if.p_write), 32'(wr));
      chk("acc_wdata", bus_if.p_wdata, wdata);
      chk("acc_strb", 32'(bus_if.p_strb), 32'(e_strb));
      chk("acc_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      @(negedge p_clk);
    end
    chk("access_cycles", 32'(acc), 32'(e_acc));
    chk("resp_sel", 32'(bus_if.p_sel), 32'd0);
    chk("resp_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("resp_err", 32'(bus_if.rsp_err), 32'(e_err));
    chk("resp_rdata", bus_if.rsp_rdata, e_rdata);
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge p_clk);
      chk("bp_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("bp_err", 32'(bus_if.rsp_err), 32'(e_err));
      chk("bp_rdata", bus_if.rsp_rdata, e_rdata);
      chk("bp_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge p_clk);
    bus_if.rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    int          wt;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_wdata = '0;
    bus_if.cmd_strb  = '0;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ra = $urandom;
      mem[i] = ra;
      shadow[i] = ra;
    end

    repeat (2) @(negedge p_clk);
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_sel", 32'(bus_if.p_sel), 32'd0);
    chk("rst_enable", 32'(bus_if.p_enable), 32'd0);
    chk("rst_addr", bus_if.p_addr, 32'd0);
    chk("rst_rdata", bus_if.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus_if.rsp_err), 32'd0);
    p_resetn = 1'b1;
    @(negedge p_clk);
    chk("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

    do_cmd(32'h10, 1'b1, 32'hA5A5_5A5A, 4'hF, 0, 0, 1'b0, 1'b0);
    do_cmd(32'h0, 1'b1, 32'h4433_2211, 4'hF, 3, 1, 1'b0, 1'b0);
    do_cmd(32'h0, 1'b0, 32'h1234_5678, 4'hF, 3, 0, 1'b0, 1'b0);
    do_cmd(32'd62, 1'b1, 32'hCAFE_F00D, 4'hF, 3, 0, 1'b0, 1'b0);
    do_cmd(32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);
    do_cmd(32'h7, 1'b1, 32'h0BAD_0BAD, 4'h0, 1, 0, 1'b0, 1'b0);
    do_cmd(32'h21, 1'b0, 32'h0, 4'h0, 1000, 0, 1'b0, 1'b0);
    do_cmd(32'h0, 1'b0, 32'h0, 4'h0, TC - 1, 0, 1'b0, 1'b0);
    do_cmd(32'h5, 1'b1, 32'h1357_9BDF, 4'h5, 0, 10, 1'b1, 1'b0);
    do_cmd(32'h5, 1'b1, 32'h1357_9BDF, 4'h5, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of a hung ACCESS phase.
    wait_cfg = 1000;
    bus_if.cmd_addr  = 32'h3;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_wdata = 32'hFFFF_FFFF;
    bus_if.cmd_strb  = 4'hF;
    bus_if.cmd_valid = 1'b1;
    @(negedge p_clk);
    bus_if.cmd_valid = 1'b0;
    repeat (3) @(negedge p_clk);
    chk("pre_rst_enable", 32'(bus_if.p_enable), 32'd1);
    #2 p_resetn = 1'b0;
    #1;
    chk("arst_sel", 32'(bus_if.p_sel), 32'd0);
    chk("arst_enable", 32'(bus_if.p_enable), 32'd0);
    chk("arst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge p_clk);
    p_resetn = 1'b1;
    @(negedge p_clk);
    chk("rel_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("no_stale_rsp", 32'(bus_if.rsp_valid), 32'd0);
      chk("no_stale_sel", 32'(bus_if.p_sel), 32'd0);
      @(negedge p_clk);
    end
    do_cmd(32'h3, 1'b0, 32'h0, 4'h0, 2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      wt = (r == 9) ? 40 : $urandom_range(0, 4);
      do_cmd($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             wt, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
